// File: rtl/aes_masked_pkg.sv
// Shared widths and the two-share block type used on the masked AES receive path.
package aes_masked_pkg;

    localparam int BEAT_W  = 64;
    localparam int BLOCK_W = 128;

    typedef struct packed {
        logic [BLOCK_W-1:0] s1;
        logic [BLOCK_W-1:0] s0;
    } share_block_t;

endpackage

// File: rtl/share_fifo.sv
// Circular-buffer FIFO with separate occupancy count; head entry is read straight from the
// storage registers so a block pushed at one edge is visible in the following cycle.
module share_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    // When full, a write is still allowed if the head leaves at the same edge.
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (wr_en && !rd_en) begin
                count_reg <= count_reg + 1'b1;
            end else if (!wr_en && rd_en) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/cipher_out_collector.sv
// Reassembles two-share 64-bit ciphertext beats into 128-bit share pairs and queues them.
// Define REMASK_EN to refresh both shares of every beat with r before storage.
module cipher_out_collector
    import aes_masked_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     done,
    input  logic                     beat_valid,
    input  logic [BEAT_W-1:0]        OutputData0,
    input  logic [BEAT_W-1:0]        OutputData1,
    input  logic [BEAT_W-1:0]        r,
    output logic [BLOCK_W-1:0]       ct0,
    output logic [BLOCK_W-1:0]       ct1,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overflow,
    output logic                     sync_err,
    output logic [$clog2(DEPTH):0]   level
);

    logic [BEAT_W-1:0] beat0;
    logic [BEAT_W-1:0] beat1;
    logic [BEAT_W-1:0] pend0_reg;
    logic [BEAT_W-1:0] pend1_reg;
    logic              half_reg;
    logic              overflow_reg;
    logic              sync_err_reg;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    share_block_t      push_blk;
    share_block_t      head_blk;
    logic [2*BLOCK_W-1:0] head_data;

`ifdef REMASK_EN
    // Same mask on both shares keeps the unmasked value intact.
    assign beat0 = OutputData0 ^ r;
    assign beat1 = OutputData1 ^ r;
`else
    logic unused_r;
    assign unused_r = ^r;
    assign beat0    = OutputData0;
    assign beat1    = OutputData1;
`endif

    assign push        = beat_valid & ~done & half_reg;
    assign pop         = out_valid & out_ready;
    assign push_blk.s0 = {beat0, pend0_reg};
    assign push_blk.s1 = {beat1, pend1_reg};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            half_reg     <= 1'b0;
            pend0_reg    <= '0;
            pend1_reg    <= '0;
            overflow_reg <= 1'b0;
            sync_err_reg <= 1'b0;
        end else begin
            if (beat_valid) begin
                if (done || !half_reg) begin
                    // done always restarts on a low half, dropping any orphan.
                    if (done && half_reg) begin
                        sync_err_reg <= 1'b1;
                    end
                    pend0_reg <= beat0;
                    pend1_reg <= beat1;
                    half_reg  <= 1'b1;
                end else begin
                    half_reg <= 1'b0;
                end
            end
            if (push && full && !pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    share_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*BLOCK_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_blk),
        .pop       (pop),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .count     (level)
    );

    assign head_blk  = share_block_t'(head_data);
    assign ct0       = head_blk.s0;
    assign ct1       = head_blk.s1;
    assign out_valid = ~empty;
    assign overflow  = overflow_reg;
    assign sync_err  = sync_err_reg;

endmodule

// File: doc/cipher_out_collector.md
# cipher_out_collector

- Receive-side block that sits directly behind the masked AES encryption core.
- Captures the core's two-share, 64-bit-per-cycle ciphertext beats (low half first, then high half) and reassembles them into 128-bit share pairs.
- Buffers completed blocks in a small FIFO, because the half-pipelined core cannot be stalled.
- Presents blocks to downstream logic through a valid/ready handshake. Shares are never combined inside this block.

## Interface
- DEPTH, 4: FIFO capacity in 128-bit blocks. Power of two, 2..16.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- done  in  1  core's done; high on the first beat (low half) of a burst.
- beat_valid  in  1  high on every cycle carrying a valid ciphertext beat, including the done cycle.
- OutputData0  in  64  share 0 of the current beat.
- OutputData1  in  64  share 1 of the current beat.
- r  in  64  fresh randomness, used only with REMASK_EN.
- ct0  out  128  share 0 of the head block.
- ct1  out  128  share 1 of the head block.
- out_valid  out  1  head block available.
- out_ready  in  1  downstream accepts head block.
- overflow  out  1  sticky; a completed block was dropped.
- sync_err  out  1  sticky; a half block was discarded by done.
- level  out  $clog2(DEPTH)+1  blocks currently stored.

## Operation
- **Half tracking.** A half-select flag `half` is 0 after reset.
- **Beat capture.**
  - A beat with `done=1` is always treated as the low half.
  - If `half=1` when that beat arrives (a low half is already pending), the pending half is discarded and sync_err is set.
  - A beat with `done=0` goes into the half indicated by `half`, and `half` toggles.
- **Low half.** Stored in a 64-bit pending register per share.
- **High half.**
  - Completes the block: ct0 = {OutputData0, pending0}, same form for ct1.
  - The block is pushed into the FIFO at the same clock edge.
- **Back-to-back traffic.** Bursts of any even number of beats on consecutive cycles are accepted without gaps.
- **FIFO storage.**
  - Circular buffer with read and write pointers of width $clog2(DEPTH), wrapping modulo DEPTH.
  - Separate count register, 0..DEPTH.
- **Push with FIFO full.**
  - Without a same-cycle pop, the block is dropped, overflow is set, and the pointers are unchanged.
  - With a same-cycle pop (out_valid & out_ready), the push succeeds and the count is unchanged.
- **Pop.** Occurs when out_valid & out_ready. Popping while empty is impossible, since out_valid=0.
- **Beat gaps.** `done=0`, `beat_valid=0` cycles between halves are permitted; the pending half is held indefinitely.
- **Share separation.**
  - Share 0 and share 1 data paths are never XORed with each other.
  - They sit in separate register arrays with no shared combinational logic.
- **Sticky flags.** overflow and sync_err clear only on reset.

## Timing
- **Reset values.** All outputs are 0: ct0, ct1, out_valid, overflow, sync_err, level. `half`, the pointers and the pending registers are also 0.
- **Latency.**
  - High half captured at edge t → out_valid=1 and the block on ct0/ct1 in cycle t+1, if the FIFO was empty.
  - Total latency from the done beat is 2 cycles.
- **Output stability.** ct0, ct1 and out_valid are registered (FIFO head reads); they remain stable while out_valid & !out_ready.
- **Pop effect.** The next block (or out_valid=0) appears in the cycle after the accepting edge.
- **level.** Updates at the same edge as push/pop.
- **Reset mid-operation.** Asynchronous assert clears everything immediately, including a pending half; deassertion is synchronised externally.

## Configuration
- **REMASK_EN defined.**
  - Each captured beat is refreshed before storage: share 0 ^= r, share 1 ^= r.
  - The unmasked value is preserved; r is sampled on the beat cycle.
- **REMASK_EN undefined.** r is ignored, beats are stored verbatim, and no refresh XOR logic is generated.

## Structure
- **Shared package `aes_masked_pkg`.**
  - BEAT_W=64 and BLOCK_W=128.
  - `share_block_t`, a struct holding two 128-bit shares.
- **Sub-module `share_fifo`.**
  - Parameterised DEPTH and WIDTH.
  - Push/pop/full/empty/count.
  - Instantiated once with WIDTH=256 (both shares in one entry, kept as distinct fields).

## Test plan
- **Single block.**
  - Stimulus: done+beat {64'h02dc09fb3925841d ^ m, m}, next cycle beat {64'h196a0b32dc118597 ^ m', m'}, with m and m' random.
  - Required: ct0^ct1 = 128'h196a0b32dc118597_02dc09fb3925841d, out_valid in cycle 2 after done, level=1.
- **Pipelined burst.** Four consecutive beats after one done → two identical blocks, level=2, popped in order.
- **Overflow.** Out_ready=0 and DEPTH+1 blocks → level=DEPTH, overflow=1, the first DEPTH blocks intact.
- **Full FIFO, simultaneous push and pop.** Push and pop in the same cycle → no overflow, level unchanged.
- **Resync.** done, one beat, then done again → sync_err=1, and the second block is assembled correctly.
- **REMASK_EN.**
  - With REMASK_EN, r=64'hFFFFFFFF: ct0 differs from the raw share but ct0^ct1 is unchanged.
  - Asynchronous reset mid-burst clears out_valid and level immediately.
